bs_arbiter_router: RTL

Parametrised successor to the bus generator/arbiter. It serves `DRVRS` driver FIFOs on a shared bus and arbitrates between their pending packets using round-robin or fixed priority. It routes each granted packet by the destination ID in its MSBs to one driver, or to all drivers except the source for broadcast. Destination back-pressure is honoured through `full`. It sits between the per-driver FIFO models and the system bus in the DUT wrapper instantiated by the test bench.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/bs_arbiter_router.sv | 112 +++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus arbiter/router: FSM state encoding,
// ID field defaults and the destination-ID decode.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROUTE   = 2'd1,
      DELIVER = 2'd2
   } state_e;

   localparam int          ID_W_DEF     = 8;
   localparam logic [7:0]  BCAST_ID_DEF = 8'hFF;
   localparam int          MAX_DRVRS    = 16;

   // One-hot target for a unicast ID; all zeros when the ID names no driver.
   function automatic logic [MAX_DRVRS-1:0] onehot_id(input logic [31:0] id, input int drvrs);
      logic [MAX_DRVRS-1:0] oh;
      oh = '0;
      if (id < 32'(drvrs)) oh[id[3:0]] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from ptr (MODE 0) or fixed
// priority with the lowest index winning (MODE 1).
module rr_arbiter #(
   parameter int N    = 4,
   parameter int MODE = 0,
   parameter int PW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any
);

   logic [PW-1:0] idx;

   // The modulo keeps the rotating search inside 0..N-1 for non power-of-two N.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int off = 0; off < N; off++) begin
         if (MODE == 0) idx = PW'((int'(ptr) + off) % N);
         else           idx = PW'(off);
         if (!any && req[idx]) begin
            any     = 1'b1;
            gnt_idx = idx;
         end
      end
      if (any) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/bs_arbiter_router.sv
// Shared-bus arbiter/router: pops one packet from a driver FIFO, decodes its
// destination ID and pushes it to one driver or broadcasts to all others.
//
// state   | meaning
// IDLE    | waiting for any pndng; grant, latch head word, pop winner
// ROUTE   | decode ID into target mask, or drop an invalid ID
// DELIVER | wait until no target is full, then push to all targets at once
module bs_arbiter_router
   import bus_pkg::*;
#(
   parameter int              PCKG_SZ  = 16,
   parameter int              DRVRS    = 4,
   parameter int              ID_W     = ID_W_DEF,
   parameter logic [ID_W-1:0] BCAST_ID = ID_W'(BCAST_ID_DEF),
   parameter int              MODE     = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DRVRS-1:0]                pndng,
   input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
   output logic [DRVRS-1:0]                pop,
   input  logic [DRVRS-1:0]                full,
   output logic [DRVRS-1:0]                push,
   output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
   output logic                            busy,
   output logic [7:0]                      drop_cnt
);

   localparam int              PW       = $clog2(DRVRS);
   localparam logic [ID_W-1:0] DRVRS_ID = ID_W'(DRVRS);

   state_e               state;
   logic [PCKG_SZ-1:0]   pkt;
   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        src;
   logic [DRVRS-1:0]     mask;
   logic [DRVRS-1:0]     gnt;
   logic [PW-1:0]        gnt_idx;
   logic                 any;
   logic [ID_W-1:0]      id;
   logic [MAX_DRVRS-1:0] oh;
   logic [DRVRS-1:0]     mask_uni;
   logic [DRVRS-1:0]     mask_bc;

   rr_arbiter #(.N(DRVRS), .MODE(MODE), .PW(PW)) u_arb (
      .req     (pndng),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   always_comb begin
      id          = pkt[PCKG_SZ-1 -: ID_W];
      oh          = onehot_id(32'(id), DRVRS);
      mask_uni    = oh[DRVRS-1:0];
      mask_bc     = '1;
      mask_bc[src] = 1'b0;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         pkt      <= '0;
         rr_ptr   <= '0;
         src      <= '0;
         mask     <= '0;
         pop      <= '0;
         push     <= '0;
         D_push   <= '0;
         drop_cnt <= '0;
      end else begin
         pop  <= '0;
         push <= '0;
         case (state)
            IDLE: begin
               if (any) begin
                  pkt   <= D_pop[gnt_idx];
                  src   <= gnt_idx;
                  pop   <= gnt;
                  state <= ROUTE;
                  if (MODE == 0)
                     rr_ptr <= (gnt_idx == PW'(DRVRS-1)) ? '0 : gnt_idx + 1'b1;
               end
            end
            ROUTE: begin
               if (id < DRVRS_ID) begin
                  mask  <= mask_uni;
                  state <= DELIVER;
               end else if (id == BCAST_ID) begin
                  mask  <= mask_bc;
                  state <= DELIVER;
               end else begin
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                  state <= IDLE;
               end
            end
            DELIVER: begin
               if ((full & mask) == '0) begin
                  push   <= mask;
                  D_push <= {DRVRS{pkt}};
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
